// File: rtl/addsub_sched_if.sv
// Client-facing bundle of the addsub_sched block: two request ports, the shared
// result/status, and a debug view of the scheduler state.
interface addsub_sched_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  // Handshake: requester i raises req[i] with op/a/b and holds them until it
  // sees done[i]. It then drops req[i] on the edge that ends the done cycle,
  // or keeps it high to issue a new request. Dropping req[i] before the grant
  // withdraws the request. result/ofFlag are valid while done is high.
  logic [1:0]       req;
  logic             op0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;
  logic             ofFlag;
  logic             busy;
  logic [CNT_W-1:0] ovf_cnt;
  logic             cnt_clr;
  logic [1:0]       dbg_state;

  modport master (
    output req, op0, a0, b0, op1, a1, b1, cnt_clr,
    input  done, result, ofFlag, busy, ovf_cnt, dbg_state
  );

  modport slave (
    input  req, op0, a0, b0, op1, a1, b1, cnt_clr,
    output done, result, ofFlag, busy, ovf_cnt, dbg_state
  );
endinterface

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one signed add/subtract datapath between two
// requesters, with a saturating overflow-event counter.
module addsub_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ptr;
  logic             r_id;
  logic             r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_of;
  logic [1:0]       r_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_win;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  // Subtract is a + ~b + 1, so both opcodes share one adder; overflow is the
  // usual same-sign-in, different-sign-out test on the effective operands.
  always_comb begin
    w_win = (bus.req == 2'b11) ? r_ptr : bus.req[1];
    w_bx  = r_op ? ~r_b : r_b;
    w_sum = r_a + w_bx + {{(WIDTH-1){1'b0}}, r_op};
    w_ovf = (r_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_id     <= 1'b0;
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_of     <= 1'b0;
      r_done   <= 2'b00;
      r_cnt    <= '0;
    end else begin
      r_done <= 2'b00;

      if (bus.cnt_clr)
        r_cnt <= '0;
      else if ((r_state == EXEC) && w_ovf && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            r_id    <= w_win;
            r_op    <= w_win ? bus.op1 : bus.op0;
            r_a     <= w_win ? bus.a1  : bus.a0;
            r_b     <= w_win ? bus.b1  : bus.b0;
            r_ptr   <= ~w_win;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result <= w_sum;
          r_of     <= w_ovf;
          r_done   <= r_id ? 2'b10 : 2'b01;
          r_state  <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.ofFlag    = r_of;
  assign bus.busy      = (r_state != IDLE);
  assign bus.ovf_cnt   = r_cnt;
  assign bus.dbg_state = r_state;

endmodule
